// File: rtl/trail_iir_if.sv
`default_nettype none
// ============================================================================
//  Module      : trail_iir_if
//  Description : Pixel stream bundle for the glow-trail IIR blender. The
//                master side supplies history/camera pixels, the slave side
//                returns the updated trail pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trail_iir_if;
  logic        valid_in;
  logic [23:0] history_in;
  logic [23:0] camera_in;
  logic [23:0] update_out;
  logic        valid_out;

  // Pixel source / result sink (frame-buffer read port and display side)
  modport master (
    output valid_in,
    output history_in,
    output camera_in,
    input  update_out,
    input  valid_out
  );

  // Blender core
  modport slave (
    input  valid_in,
    input  history_in,
    input  camera_in,
    output update_out,
    output valid_out
  );
endinterface : trail_iir_if
`default_nettype wire

// File: rtl/trail_iir_core.sv
`default_nettype none
// ============================================================================
//  Module      : trail_iir_core
//  Description : Per-pixel RGB IIR blender. Each channel computes
//                u = min(255, (h*DECAY + c*GAIN) >> 8) in a three-stage
//                pipeline (products, sums, shift+saturate). One pixel per
//                clock, no backpressure, latency of two edges after sampling.
//  Revision    : 1.0 - initial release
// ============================================================================
module trail_iir_core #(
  parameter logic [8:0] DECAY = 9'd224,  // history weight, numerator over 256
  parameter logic [8:0] GAIN  = 9'd32    // camera weight, numerator over 256
) (
  input  logic       clk_in,
  input  logic       rst_in,             // asynchronous, active-low
  trail_iir_if.slave bus
);

  localparam int unsigned c_NCH = 3;

  // Valid bits travel alongside the data: [0] products, [1] sums, [2] output.
  logic [2:0]  r_vld;
  logic [23:0] w_update;

  // Valid shift register; the only control state, so it alone carries reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vld <= 3'b000;
    end else begin
      r_vld <= {r_vld[1:0], bus.valid_in};
    end
  end

  generate
    for (genvar ch = 0; ch < c_NCH; ch++) begin : g_ch
      logic [7:0]  w_h;
      logic [7:0]  w_c;
      logic [16:0] w_prod_h;
      logic [16:0] w_prod_c;
      logic [16:0] r_prod_h;
      logic [16:0] r_prod_c;
      logic [17:0] r_sum;
      logic [9:0]  w_shift;
      logic [7:0]  w_sat;
      logic [7:0]  r_out;

      assign w_h = bus.history_in[ch*8 +: 8];
      assign w_c = bus.camera_in[ch*8 +: 8];

      // 8x9 products fit in 17 bits (255*256 = 65280)
      assign w_prod_h = 17'(w_h) * 17'(DECAY);
      assign w_prod_c = 17'(w_c) * 17'(GAIN);

      // Stage 1: capture products; idle cycles leave the registers untouched
      // so garbage on the inputs never enters the datapath.
      always_ff @(posedge clk_in) begin
        if (bus.valid_in) begin
          r_prod_h <= w_prod_h;
          r_prod_c <= w_prod_c;
        end
      end

      // Stage 2: 18-bit sum so the worst case (2*65280) cannot wrap
      always_ff @(posedge clk_in) begin
        if (r_vld[0]) begin
          r_sum <= {1'b0, r_prod_h} + {1'b0, r_prod_c};
        end
      end

      // Truncating divide by 256, then clamp anything above 255
      assign w_shift = r_sum[17:8];
      assign w_sat   = (|w_shift[9:8]) ? 8'hFF : w_shift[7:0];

      // Stage 3: output register; cleared by reset, holds while idle
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_out <= 8'h00;
        end else if (r_vld[1]) begin
          r_out <= w_sat;
        end
      end

      assign w_update[ch*8 +: 8] = r_out;
    end : g_ch
  endgenerate

  assign bus.update_out = w_update;
  assign bus.valid_out  = r_vld[2];

endmodule : trail_iir_core
`default_nettype wire

// File: tb/tb_trail_iir_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trail_iir_core
//  Description : Directed bench for trail_iir_core. Four instances share one
//                input stream: defaults (224/32), saturating (256/256),
//                history pass-through (256/0) and camera pass-through (0/256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trail_iir_core;

  typedef struct {
    logic [23:0] h;
    logic [23:0] c;
    logic [23:0] exp_def;  // DECAY=224, GAIN=32 : floor((7h+c)/8)
    logic [23:0] exp_sat;  // DECAY=256, GAIN=256: min(255, h+c)
  } vec_t;

  localparam int c_NV = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [c_NV];

  always #5 clk = ~clk;

  trail_iir_if if_def ();
  trail_iir_if if_sat ();
  trail_iir_if if_hp  ();
  trail_iir_if if_cp  ();

  trail_iir_core #(.DECAY(9'd224), .GAIN(9'd32))  u_def (.clk_in(clk), .rst_in(rst_n), .bus(if_def));
  trail_iir_core #(.DECAY(9'd256), .GAIN(9'd256)) u_sat (.clk_in(clk), .rst_in(rst_n), .bus(if_sat));
  trail_iir_core #(.DECAY(9'd256), .GAIN(9'd0))   u_hp  (.clk_in(clk), .rst_in(rst_n), .bus(if_hp));
  trail_iir_core #(.DECAY(9'd0),   .GAIN(9'd256)) u_cp  (.clk_in(clk), .rst_in(rst_n), .bus(if_cp));

  task automatic drive(input logic v, input logic [23:0] h, input logic [23:0] c);
    if_def.valid_in = v; if_def.history_in = h; if_def.camera_in = c;
    if_sat.valid_in = v; if_sat.history_in = h; if_sat.camera_in = c;
    if_hp.valid_in  = v; if_hp.history_in  = h; if_hp.camera_in  = c;
    if_cp.valid_in  = v; if_cp.history_in  = h; if_cp.camera_in  = c;
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_valid(input string name, input logic exp);
    chk({name, "_vdef"}, 24'(if_def.valid_out), 24'(exp));
    chk({name, "_vsat"}, 24'(if_sat.valid_out), 24'(exp));
    chk({name, "_vhp"},  24'(if_hp.valid_out),  24'(exp));
    chk({name, "_vcp"},  24'(if_cp.valid_out),  24'(exp));
  endtask

  task automatic chk_data(input string name, input int idx);
    chk({name, "_def"}, if_def.update_out, vecs[idx].exp_def);
    chk({name, "_sat"}, if_sat.update_out, vecs[idx].exp_sat);
    chk({name, "_hp"},  if_hp.update_out,  vecs[idx].h);
    chk({name, "_cp"},  if_cp.update_out,  vecs[idx].c);
  endtask

  task automatic chk_zero(input string name);
    chk_valid(name, 1'b0);
    chk({name, "_def0"}, if_def.update_out, 24'h000000);
    chk({name, "_sat0"}, if_sat.update_out, 24'h000000);
    chk({name, "_hp0"},  if_hp.update_out,  24'h000000);
    chk({name, "_cp0"},  if_cp.update_out,  24'h000000);
  endtask

  // Isolated pulse: result after two edges, one-cycle valid, value then held
  task automatic pulse_check(input string name, input int idx);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (t == 1 || t == 2) chk_valid({name, "_early"}, 1'b0);
      if (t == 3) begin
        chk_valid({name, "_on"}, 1'b1);
        chk_data({name, "_data"}, idx);
      end
      if (t == 4) begin
        chk_valid({name, "_off"}, 1'b0);
        chk_data({name, "_hold"}, idx);
      end
      if (t == 0) drive(1'b1, vecs[idx].h, vecs[idx].c);
      else        drive(1'b0, 24'hxxxxxx, 24'hxxxxxx);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{24'h000000, 24'h123456, 24'h02060A, 24'h123456};
    vecs[1] = '{24'hFAF078, 24'h123456, 24'hDDD873, 24'hFFFFCE};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{24'h800000, 24'h900000, 24'h820000, 24'hFF0000};
    vecs[4] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000};
    vecs[5] = '{24'h102030, 24'h405060, 24'h162636, 24'h507090};
    vecs[6] = '{24'h010101, 24'h000000, 24'h000000, 24'h010101};
    vecs[7] = '{24'h0A0B0C, 24'hFFFFFF, 24'h28292A, 24'hFFFFFF};
    vecs[8] = '{24'h7F7F7F, 24'h010203, 24'h6F6F6F, 24'h808182};
    vecs[9] = '{24'hFFFFFF, 24'h000000, 24'hDFDFDF, 24'hFFFFFF};

    // Reset from time zero, then release and confirm quiet idle outputs
    rst_n = 1'b0;
    drive(1'b0, 24'h000000, 24'h000000);
    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk_zero("post_reset");
    end

    // Isolated pulses
    pulse_check("empty_hist", 0);
    pulse_check("bright_hist", 1);

    // Back-to-back stream of the whole table: exact latency, no gaps
    for (int t = 0; t < c_NV + 3; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        chk_valid("stream_v", 1'b1);
        chk_data($sformatf("stream%0d", t - 3), t - 3);
      end
      if (t < c_NV) drive(1'b1, vecs[t].h, vecs[t].c);
      else          drive(1'b0, 24'hxxxxxx, 24'hxxxxxx);
    end
    @(negedge clk);
    chk_valid("stream_end", 1'b0);
    chk_data("stream_end_hold", c_NV - 1);

    // Mid-cycle asynchronous reset one cycle after a pulse
    drive(1'b1, vecs[1].h, vecs[1].c);
    @(negedge clk);
    drive(1'b0, 24'hxxxxxx, 24'hxxxxxx);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk_zero("flushed");
    end

    // Recovery after reset
    pulse_check("recover", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_trail_iir_core
`default_nettype wire
